// File: rtl/ofmap_pkg.sv
// Shared state encoding and geometry helpers for the ofmap write controller.
package ofmap_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRun   = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  // Default-geometry constants; parameterised instances use the helpers below.
  localparam int unsigned OFMAP_PIXELS = 14 * 14;
  localparam int unsigned CH_TILES     = 64 / 16;

  function automatic int unsigned pixel_count(input int unsigned width, input int unsigned height);
    return width * height;
  endfunction

  function automatic int unsigned ch_tile_count(input int unsigned channels,
                                                input int unsigned lanes);
    return channels / lanes;
  endfunction

endpackage

// File: rtl/ofmap_rmw_pipe.sv
// Read-modify-write pipeline: stage registers plus per-lane wrap-around adders.
module ofmap_rmw_pipe #(
  parameter int unsigned MAC_COL        = 16,
  parameter int unsigned OFMAP_BITWIDTH = 32,
  parameter int unsigned OFMAP_ADDR_BIT = 10
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                beat_valid_i,
  input  logic [OFMAP_ADDR_BIT-1:0]           beat_addr_i,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   beat_psum_i,
  input  logic                                first_pass_i,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0]   rd_data_i,
  output logic                                read_en_o,
  output logic [OFMAP_ADDR_BIT-1:0]           read_addr_o,
  output logic                                write_en_o,
  output logic [OFMAP_ADDR_BIT-1:0]           write_addr_o,
  output logic [MAC_COL*OFMAP_BITWIDTH-1:0]   write_data_o,
  output logic                                busy_o
);

  localparam int unsigned DataW = MAC_COL * OFMAP_BITWIDTH;

  logic                      s1_valid_q, s2_valid_q, wr_en_q;
  logic [OFMAP_ADDR_BIT-1:0] s1_addr_q, s2_addr_q, wr_addr_q;
  logic [DataW-1:0]          s1_psum_q, s2_psum_q, wr_data_q;
  logic [DataW-1:0]          sum_d;

  // Each lane wraps independently; the slice width drops any carry-out.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(MAC_COL); i++) begin
      sum_d[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] =
          s2_psum_q[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH] +
          (first_pass_i ? '0 : rd_data_i[i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_psum_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_psum_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      s1_valid_q <= beat_valid_i;
      if (beat_valid_i) begin
        s1_addr_q <= beat_addr_i;
        s1_psum_q <= beat_psum_i;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_psum_q <= s1_psum_q;
      end
      wr_en_q <= s2_valid_q;
      if (s2_valid_q) begin
        wr_addr_q <= s2_addr_q;
        wr_data_q <= sum_d;
      end
    end
  end

  assign read_en_o    = s1_valid_q & ~first_pass_i;
  assign read_addr_o  = s1_addr_q;
  assign write_en_o   = wr_en_q;
  assign write_addr_o = wr_addr_q;
  assign write_data_o = wr_data_q;
  // The beat in the write register retires this cycle, so it does not hold off DONE.
  assign busy_o       = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/ofmap_write_controller.sv
// Ofmap write controller: pass FSM, raster pixel counters and address generation.
module ofmap_write_controller
  import ofmap_pkg::*;
#(
  parameter int unsigned MAC_COL           = 16,
  parameter int unsigned OFMAP_BITWIDTH    = 32,
  parameter int unsigned OFMAP_ADDR_BIT    = 10,
  parameter int unsigned OFMAP_CHANNEL_NUM = 64,
  parameter int unsigned OFMAP_WIDTH       = 14,
  parameter int unsigned OFMAP_HEIGHT      = 14
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              ofmap_start_in,
  input  logic                              first_pass_in,
  input  logic                              last_pass_in,
  input  logic [31:0]                       O_CH_MAC_COL_count,
  input  logic                              psum_valid_in,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] psum_in,
  input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] ofmap_data_in,
  output logic                              ofmap_read_en_out,
  output logic [OFMAP_ADDR_BIT-1:0]         ofmap_read_addr_out,
  output logic                              ofmap_write_en_out,
  output logic [OFMAP_ADDR_BIT-1:0]         ofmap_write_addr_out,
  output logic [MAC_COL*OFMAP_BITWIDTH-1:0] ofmap_data_out,
  output logic                              pass_done_out,
  output logic                              ofmap_done_out,
  output logic                              overrun_err_out
);

  localparam int unsigned ChTiles = ch_tile_count(OFMAP_CHANNEL_NUM, MAC_COL);
  localparam int unsigned Pixels  = pixel_count(OFMAP_WIDTH, OFMAP_HEIGHT);
  localparam int unsigned WBits   = (OFMAP_WIDTH > 1) ? $clog2(OFMAP_WIDTH) : 1;
  localparam int unsigned HBits   = (OFMAP_HEIGHT > 1) ? $clog2(OFMAP_HEIGHT) : 1;

  state_t                    state_q, state_d;
  logic [WBits-1:0]          o_w_q, o_w_d;
  logic [HBits-1:0]          o_h_q, o_h_d;
  logic                      first_q, last_q, overrun_q;
  logic [31:0]               tile_q;
  logic                      beat_acc, w_wrap, h_wrap, pipe_busy;
  logic [OFMAP_ADDR_BIT-1:0] beat_addr;

  assign beat_acc = (state_q == StRun) && psum_valid_in;
  assign w_wrap   = (o_w_q == WBits'(OFMAP_WIDTH - 1));
  assign h_wrap   = (o_h_q == HBits'(OFMAP_HEIGHT - 1));

  // Channel-interleaved layout: all tiles of a pixel sit at consecutive addresses.
  assign beat_addr = OFMAP_ADDR_BIT'(
      (32'(o_h_q) * OFMAP_WIDTH + 32'(o_w_q)) * ChTiles + tile_q);

  always_comb begin
    state_d = state_q;
    o_w_d   = o_w_q;
    o_h_d   = o_h_q;
    case (state_q)
      StIdle: begin
        if (ofmap_start_in) begin
          state_d = StRun;
          o_w_d   = '0;
          o_h_d   = '0;
        end
      end
      StRun: begin
        if (beat_acc) begin
          if (w_wrap) begin
            o_w_d = '0;
            o_h_d = h_wrap ? '0 : o_h_q + 1'b1;
            if (h_wrap) state_d = StDrain;
          end else begin
            o_w_d = o_w_q + 1'b1;
          end
        end
      end
      StDrain: if (!pipe_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      o_w_q     <= '0;
      o_h_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      tile_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      o_w_q   <= o_w_d;
      o_h_q   <= o_h_d;
      if (state_q == StIdle && ofmap_start_in) begin
        first_q <= first_pass_in;
        last_q  <= last_pass_in;
        tile_q  <= O_CH_MAC_COL_count;
      end
      if (psum_valid_in && state_q != StRun) overrun_q <= 1'b1;
    end
  end

  ofmap_rmw_pipe #(
    .MAC_COL        (MAC_COL),
    .OFMAP_BITWIDTH (OFMAP_BITWIDTH),
    .OFMAP_ADDR_BIT (OFMAP_ADDR_BIT)
  ) u_rmw_pipe (
    .clk          (clk),
    .rstn         (rstn),
    .beat_valid_i (beat_acc),
    .beat_addr_i  (beat_addr),
    .beat_psum_i  (psum_in),
    .first_pass_i (first_q),
    .rd_data_i    (ofmap_data_in),
    .read_en_o    (ofmap_read_en_out),
    .read_addr_o  (ofmap_read_addr_out),
    .write_en_o   (ofmap_write_en_out),
    .write_addr_o (ofmap_write_addr_out),
    .write_data_o (ofmap_data_out),
    .busy_o       (pipe_busy)
  );

  assign pass_done_out   = (state_q == StDone);
  assign ofmap_done_out  = (state_q == StDone) && last_q;
  assign overrun_err_out = overrun_q;

  // Pixels is the beat count at which RUN hands over to DRAIN.
  if (Pixels == 0) begin : gen_bad_geometry
    $error("ofmap geometry must be non-empty");
  end

endmodule

// File: tb/tb_ofmap_write_controller.sv
// Randomised bench: SRAM model plus a pass-level reference of expected strobes and contents.
module tb_ofmap_write_controller;

  localparam int unsigned MC = 2, BW = 8, AB = 10, CH = 4, W = 2, H = 2;
  localparam int unsigned PIX = W * H, CHT = CH / MC, DW = MC * BW;

  logic          clk = 1'b0;
  logic          rstn, start, first_in, last_in, valid;
  logic [31:0]   tile_in;
  logic [DW-1:0] psum, rdata;
  logic          read_en, write_en, pass_done, ofmap_done, overrun;
  logic [AB-1:0] raddr, waddr;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  ofmap_write_controller #(
    .MAC_COL           (MC),
    .OFMAP_BITWIDTH    (BW),
    .OFMAP_ADDR_BIT    (AB),
    .OFMAP_CHANNEL_NUM (CH),
    .OFMAP_WIDTH       (W),
    .OFMAP_HEIGHT      (H)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .ofmap_start_in       (start),
    .first_pass_in        (first_in),
    .last_pass_in         (last_in),
    .O_CH_MAC_COL_count   (tile_in),
    .psum_valid_in        (valid),
    .psum_in              (psum),
    .ofmap_data_in        (rdata),
    .ofmap_read_en_out    (read_en),
    .ofmap_read_addr_out  (raddr),
    .ofmap_write_en_out   (write_en),
    .ofmap_write_addr_out (waddr),
    .ofmap_data_out       (wdata),
    .pass_done_out        (pass_done),
    .ofmap_done_out       (ofmap_done),
    .overrun_err_out      (overrun)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // SRAM: 1-cycle read latency, garbage on the data bus when not reading.
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  always @(posedge clk) begin
    if (read_en === 1'b1) rdata <= mem[raddr];
    else                  rdata <= DW'($urandom);
    if (write_en === 1'b1) mem[waddr] = wdata;
  end

  typedef struct { int due; logic [AB-1:0] addr; logic [DW-1:0] data; } ev_t;
  typedef struct { int due; bit last; } done_t;
  ev_t   rdq[$], wrq[$];
  done_t doneq[$];

  int          cyc = 0, m_st = 0, m_cnt = 0, m_idle_at = 0;
  bit          m_err = 0, m_first = 0, m_last = 0;
  logic [31:0] m_tile = 0;

  // Reference: a pass accepts PIX beats; each beat reads at +0, writes at +2 (visible
  // after the edge), done follows the last write; the controller is busy 4 edges after.
  always @(posedge clk) begin
    ev_t         e;
    done_t       d;
    bit          er, ew, ed;
    logic [BW-1:0] old_l, p_l;
    cyc++;
    if (!rstn) begin
      m_st = 0; m_err = 0;
      rdq.delete(); wrq.delete(); doneq.delete();
    end else begin
      if (m_st == 2 && cyc >= m_idle_at) m_st = 0;
      case (m_st)
        0: begin
          if (valid) m_err = 1;
          if (start) begin
            m_first = first_in; m_last = last_in; m_tile = tile_in;
            m_st = 1; m_cnt = 0;
          end
        end
        1: if (valid) begin
          e.addr = AB'(m_cnt * CHT + m_tile);
          for (int l = 0; l < int'(MC); l++) begin
            old_l = ref_mem[e.addr][l*BW +: BW];
            p_l   = psum[l*BW +: BW];
            e.data[l*BW +: BW] = m_first ? p_l : BW'(old_l + p_l);
          end
          if (!m_first) begin e.due = cyc; rdq.push_back(e); end
          e.due = cyc + 2; wrq.push_back(e);
          m_cnt++;
          if (m_cnt == int'(PIX)) begin
            m_st = 2; m_idle_at = cyc + 5;
            d.due = cyc + 3; d.last = m_last; doneq.push_back(d);
          end
        end
        default: if (valid) m_err = 1;
      endcase
    end
    #1;
    er = rdq.size() != 0 && rdq[0].due == cyc;
    check_eq("read_en", read_en, er);
    if (er) begin
      check_eq("read_addr", raddr, rdq[0].addr);
      void'(rdq.pop_front());
    end
    ew = wrq.size() != 0 && wrq[0].due == cyc;
    check_eq("write_en", write_en, ew);
    if (ew) begin
      check_eq("write_addr", waddr, wrq[0].addr);
      check_eq("write_data", wdata, wrq[0].data);
      ref_mem[wrq[0].addr] = wrq[0].data;
      void'(wrq.pop_front());
    end
    ed = doneq.size() != 0 && doneq[0].due == cyc;
    check_eq("pass_done", pass_done, ed);
    check_eq("ofmap_done", ofmap_done, ed && doneq.size() != 0 && doneq[0].last);
    if (ed) void'(doneq.pop_front());
    check_eq("overrun", overrun, m_err);
    if (!rstn) begin
      check_eq("rst_read_addr", raddr, 0);
      check_eq("rst_write_addr", waddr, 0);
      check_eq("rst_data", wdata, 0);
    end
  end

  logic [DW-1:0] psum_tab [PIX];

  task automatic rand_psums();
    for (int p = 0; p < int'(PIX); p++) psum_tab[p] = DW'($urandom);
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic run_pass(input bit first, input bit last, input int tile, input int gap,
                          input bit rand_gap, input bit start_in_run, input bit extra_beat);
    int g;
    @(negedge clk);
    start = 1; first_in = first; last_in = last; tile_in = 32'(tile);
    @(negedge clk);
    start = 0;
    for (int p = 0; p < int'(PIX); p++) begin
      valid = 1; psum = psum_tab[p];
      if (start_in_run && p == 1) begin
        start = 1; first_in = ~first; tile_in = 32'(tile ^ 1);
      end
      @(negedge clk);
      valid = 0; start = 0; psum = DW'($urandom);
      g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
      repeat (g) @(negedge clk);
    end
    if (extra_beat) begin
      valid = 1;
      @(negedge clk);
      valid = 0;
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin mem[a] = '0; ref_mem[a] = '0; end
    rstn = 0; start = 0; first_in = 0; last_in = 0; tile_in = 0; valid = 0; psum = '0;
    repeat (3) @(negedge clk);
    rstn = 1;

    // First pass, tile 1, back-to-back.
    rand_psums();
    run_pass(1, 0, 1, 0, 0, 0, 0);

    // Accumulate over preloaded memory, last pass.
    for (int p = 0; p < int'(PIX); p++) begin
      preload(p * int'(CHT), 16'h2010);
      psum_tab[p] = 16'h0201;
    end
    run_pass(0, 1, 0, 0, 0, 0, 0);
    check_eq("accum_mem0", mem[0], 16'h2211);

    // Lane wrap without carry into the neighbour.
    rand_psums();
    preload(1, 16'h10FF);
    psum_tab[0] = 16'h0002;
    run_pass(0, 0, 1, 0, 0, 0, 0);
    check_eq("lane_wrap", mem[1], 16'h1001);

    // One beat every third cycle.
    rand_psums();
    run_pass(0, 1, 0, 2, 0, 0, 0);

    // Random passes, some with an ignored start during RUN.
    for (int i = 0; i < 8; i++) begin
      rand_psums();
      run_pass(1'($urandom), 1'($urandom), int'($urandom_range(1, 0)), 2, 1,
               1'($urandom), 0);
    end

    // Fifth beat lands in DRAIN.
    rand_psums();
    run_pass(0, 0, 1, 0, 0, 1, 1);

    // Reset after the second beat aborts the pass.
    @(negedge clk);
    start = 1; first_in = 0; last_in = 0; tile_in = 0;
    @(negedge clk);
    start = 0;
    repeat (2) begin
      valid = 1; psum = DW'($urandom);
      @(negedge clk);
    end
    valid = 0; rstn = 0;
    @(negedge clk);
    rstn = 1;
    repeat (4) @(negedge clk);

    // Fresh pass after reset restarts at address == tile.
    rand_psums();
    run_pass(1, 1, 1, 1, 1, 0, 0);

    // Valid while idle.
    valid = 1;
    @(negedge clk);
    valid = 0;
    repeat (3) @(negedge clk);

    for (int a = 0; a < int'(PIX * CHT); a++) check_eq("final_mem", mem[a], ref_mem[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofmap_write_controller.md
Name: ofmap_write_controller

Overview:
Write-side counterpart of the ifmap read controller. It accepts de-skewed partial-sum rows from the bottom of the MAC array, one output pixel per valid beat, and accumulates them into the ofmap buffer by read-modify-write. It also generates ofmap addresses in the same channel-interleaved layout the ifmap side uses. It sits between the array output de-skew stage and the ofmap SRAM, which has one read port and one write port and 1-cycle read latency.

Parameters:
MAC_COL, 16, array columns = output-channel lanes per beat
OFMAP_BITWIDTH, 32, bits per lane
OFMAP_ADDR_BIT, 10, ofmap buffer address width
OFMAP_CHANNEL_NUM, 64, total output channels
OFMAP_WIDTH, 14, output pixels per row
OFMAP_HEIGHT, 14, output rows

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ofmap_start_in  in  1  pulse: begin one accumulation pass
first_pass_in  in  1  sampled with start; 1 = overwrite, no read
last_pass_in  in  1  sampled with start; 1 = final pass, raises ofmap_done_out at end
O_CH_MAC_COL_count  in  32  output-channel tile index, sampled with start
psum_valid_in  in  1  one beat = one pixel, raster order (W fastest)
psum_in  in  MAC_COL*OFMAP_BITWIDTH  lane i at bits [i*OFMAP_BITWIDTH +: OFMAP_BITWIDTH]
ofmap_data_in  in  MAC_COL*OFMAP_BITWIDTH  SRAM read data, valid 1 cycle after read_en
ofmap_read_en_out  out  1  SRAM read strobe
ofmap_read_addr_out  out  OFMAP_ADDR_BIT  read address
ofmap_write_en_out  out  1  SRAM write strobe
ofmap_write_addr_out  out  OFMAP_ADDR_BIT  write address
ofmap_data_out  out  MAC_COL*OFMAP_BITWIDTH  write data
pass_done_out  out  1  1-cycle pulse after last write of a pass
ofmap_done_out  out  1  1-cycle pulse with pass_done_out when the pass is the last pass
overrun_err_out  out  1  sticky: a valid beat arrived outside RUN or beyond the pixel count

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, counters 0, all outputs 0 including data and addresses, overrun_err_out cleared. Reset mid-pass aborts with no further strobes.
- FSM states (shared enum):
  - IDLE: on ofmap_start_in, latch first/last/tile and go to RUN.
  - RUN: each psum_valid_in beat advances O_W, and O_H on O_W wrap. When beat OFMAP_WIDTH*OFMAP_HEIGHT-1 is accepted, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: one cycle; pass_done_out=1, ofmap_done_out=latched last; then IDLE.
- ofmap_start_in outside IDLE is ignored.
- Address = (O_H*OFMAP_WIDTH + O_W)*(OFMAP_CHANNEL_NUM/MAC_COL) + tile, truncated to OFMAP_ADDR_BIT.
- Pipeline for a beat sampled at edge t:
  - Stage 1 (t+1): read_en=1 with that address, suppressed when first pass. Address, psum and valid are registered.
  - Stage 2 (t+2): ofmap_data_in returns. Per lane, sum = psum + rdata, or psum alone on the first pass. Sum is modulo 2^OFMAP_BITWIDTH, no saturation, no cross-lane carry. Sum is registered.
  - Write (t+3): write_en=1 with the same address and the registered sum.
- Latency from beat to write is fixed at 3 cycles, including the first pass.
- Back-to-back beats sustain 1 pixel/cycle. Addresses in flight are distinct within a pass, so there is no RAW hazard. A read and a write in the same cycle use separate ports.
- Next pass: a start in the cycle after DONE is legal. The first read of that pass is never issued before the last write of the previous pass.
- Strobes: read_en and write_en are 0 whenever no beat is in the corresponding stage. Address and data hold their last value when idle.
- Overrun: psum_valid_in in IDLE, DRAIN or DONE sets overrun_err_out, and the beat is dropped. The error clears only on reset.

Decomposition:
- Package ofmap_pkg: state enum {IDLE, RUN, DRAIN, DONE}, constant OFMAP_PIXELS = OFMAP_WIDTH*OFMAP_HEIGHT, constant CH_TILES = OFMAP_CHANNEL_NUM/MAC_COL.
- One sub-module, ofmap_rmw_pipe: the stage registers and per-lane adder array. The FSM and pixel counters stay in the top module.

Test Plan:
- Params MAC_COL=2, BITWIDTH=8, CH=4, W=H=2. First pass, tile 1, four back-to-back beats -> writes at addresses 1,3,5,7, each exactly 3 cycles after its beat. No read_en. pass_done 1 cycle after the last write. ofmap_done=0.
- Second pass over preloaded memory {0x10,0x20} per address, psum {0x01,0x02} -> read at t+1, write {0x11,0x22} at t+3. Last pass -> ofmap_done pulses with pass_done.
- Lane wrap: mem lane 0xFF, psum 0x02 -> written 0x01. Neighbouring lane unchanged, with no carry into it.
- Gapped valids (one beat every 3 cycles) -> identical addresses and data, strobes only on beat cycles, done after the 4th write.
- psum_valid_in in IDLE, and a 5th beat in DRAIN -> overrun_err_out=1 sticky, no extra write. Start in RUN is ignored.
- rstn=0 after the 2nd beat -> next edge all outputs 0 and no later strobes. A new start then begins again at address = tile.
